// File: rtl/i2c_mst.sv
// i2c_mst: byte-level I2C master, open-drain SCL/SDA with clock stretching.
// Define I2C_MST_ARB_EN to enable arbitration-loss detection.
module i2c_mst #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cr_en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_sta,
  input  logic             cmd_sto,
  input  logic             cmd_rd,
  input  logic             cmd_ack,
  input  logic [7:0]       cmd_dat,
  output logic [7:0]       rx_dat,
  output logic             rx_nak,
  output logic             done,
  output logic             cmd_err,
  output logic             arb_lost,
  output logic             owned,
  output logic             scl_o,
  input  logic             scl_i,
  output logic             sda_o,
  input  logic             sda_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       sh_q, sh_d;
  logic [7:0]       rx_q, rx_d;
  logic             sto_q, sto_d;
  logic             rd_q, rd_d;
  logic             ack_q, ack_d;
  logic             nak_q, nak_d;
  logic             rxn_q, rxn_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             arb_q, arb_d;
  logic             own_q, own_d;
  logic             scl_last_q;
  logic             busy, stall, tick, samp, last, acc, lost;

  // Line levels follow the current state/quarter directly
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    unique case (state_q)
      S_START: begin
        scl_o = (qtr_q == 2'd0) ? scl_last_q : (qtr_q != 2'd3);
        sda_o = (qtr_q < 2'd2);
      end
      S_DATA: begin
        scl_o = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        if (bit_q == 4'd0) sda_o = rd_q ? ack_q : 1'b1;
        else               sda_o = rd_q ? 1'b1 : tx_q[7];
      end
      S_STOP: begin
        scl_o = (qtr_q != 2'd0);
        sda_o = (qtr_q >= 2'd2);
      end
      S_HOLD: begin
        scl_o = 1'b0;
        sda_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == S_START) || (state_q == S_DATA) ||
                (state_q == S_STOP);
  assign stall = (qtr_q == 2'd1) && !scl_i;
  assign tick = busy && !stall && (cnt_q == pre_q);
  assign samp = tick && (qtr_q == 2'd1);
  assign last = tick && (qtr_q == 2'd3);
  assign cmd_ready = cr_en &&
                     ((state_q == S_IDLE) || (state_q == S_HOLD));
  assign acc = cmd_valid && cmd_ready;

`ifdef I2C_MST_ARB_EN
  // Only bits this master actually drives can be lost
  always_comb begin
    lost = 1'b0;
    if (samp && sda_o && !sda_i) begin
      if (state_q == S_START) lost = 1'b1;
      if (state_q == S_DATA &&
          ((bit_q == 4'd0) ? rd_q : !rd_q)) lost = 1'b1;
    end
  end
`else
  assign lost = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    sto_d   = sto_q;
    rd_d    = rd_q;
    ack_d   = ack_q;
    nak_d   = nak_q;
    rxn_d   = rxn_q;
    own_d   = own_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    arb_d   = 1'b0;

    if (busy && !stall) cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) qtr_d = qtr_q + 2'd1;
    if (samp && state_q == S_DATA) begin
      if (bit_q == 4'd0) nak_d = sda_i;
      else               sh_d  = {sh_q[6:0], sda_i};
    end

    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (acc) begin
          pre_d = prescale;
          cnt_d = '0;
          qtr_d = 2'd0;
          bit_d = 4'd8;
          tx_d  = cmd_dat;
          sto_d = cmd_sto;
          rd_d  = cmd_rd;
          ack_d = cmd_ack;
          if (cmd_sta) begin
            state_d = S_START;
            own_d   = 1'b1;
          end else if (state_q == S_HOLD) begin
            state_d = S_DATA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_START: if (last) state_d = S_DATA;
      S_DATA: begin
        if (last) begin
          tx_d = {tx_q[6:0], 1'b0};
          if (bit_q != 4'd0) begin
            bit_d = bit_q - 4'd1;
          end else if (sto_q) begin
            state_d = S_STOP;
          end else begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            if (rd_q) rx_d  = sh_q;
            else      rxn_d = nak_q;
          end
        end
      end
      S_STOP: begin
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          own_d   = 1'b0;
          if (rd_q) rx_d  = sh_q;
          else      rxn_d = nak_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (lost) begin
      state_d = S_IDLE;
      own_d   = 1'b0;
      arb_d   = 1'b1;
      done_d  = 1'b1;
    end
    if (!cr_en) begin
      state_d = S_IDLE;
      own_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      arb_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      cnt_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      tx_q       <= 8'd0;
      sh_q       <= 8'd0;
      rx_q       <= 8'd0;
      sto_q      <= 1'b0;
      rd_q       <= 1'b0;
      ack_q      <= 1'b0;
      nak_q      <= 1'b0;
      rxn_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      arb_q      <= 1'b0;
      own_q      <= 1'b0;
      scl_last_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      sto_q      <= sto_d;
      rd_q       <= rd_d;
      ack_q      <= ack_d;
      nak_q      <= nak_d;
      rxn_q      <= rxn_d;
      done_q     <= done_d;
      err_q      <= err_d;
      arb_q      <= arb_d;
      own_q      <= own_d;
      scl_last_q <= scl_o;
    end
  end

  assign rx_dat   = rx_q;
  assign rx_nak   = rxn_q;
  assign done     = done_q;
  assign cmd_err  = err_q;
  assign arb_lost = arb_q;
  assign owned    = own_q;

endmodule

// File: tb/tb_i2c_mst.sv
// tb_i2c_mst: directed bench for i2c_mst with a small I2C slave/bus model.
// Arbitration case runs only when I2C_MST_ARB_EN is defined.
`timescale 1ns/1ps
module tb_i2c_mst;

  logic        clk = 1'b0;
  logic        rstn, cr_en;
  logic [15:0] prescale;
  logic        cmd_valid, cmd_ready;
  logic        cmd_sta, cmd_sto, cmd_rd, cmd_ack;
  logic [7:0]  cmd_dat, rx_dat;
  logic        rx_nak, done, cmd_err, arb_lost, owned;
  logic        scl_o, scl_i, sda_o, sda_i;

  always #5 clk = ~clk;

  i2c_mst #(.PRE_W(16)) dut (
    .clk(clk), .rstn(rstn), .cr_en(cr_en), .prescale(prescale),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sta(cmd_sta), .cmd_sto(cmd_sto), .cmd_rd(cmd_rd),
    .cmd_ack(cmd_ack), .cmd_dat(cmd_dat),
    .rx_dat(rx_dat), .rx_nak(rx_nak), .done(done),
    .cmd_err(cmd_err), .arb_lost(arb_lost), .owned(owned),
    .scl_o(scl_o), .scl_i(scl_i), .sda_o(sda_o), .sda_i(sda_i)
  );

  // Stimulus-side controls (written only by the initial block)
  int          tok = 0;
  logic [8:0]  pat_init = 9'h1FF;
  logic        sta_cur = 1'b0;
  logic        stretch = 1'b0;
  logic        comp_en = 1'b0;

  // Bus model state (written only by the monitor)
  int          cyc = 0;
  int          tok_seen = 0;
  logic [8:0]  pat_q = 9'h1FF;
  logic        slv_on = 1'b0;
  int          dcnt = 0;
  int          st_cnt = 0;
  logic        st_low = 1'b0;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  logic [9:0]  cap = '0;
  int          per = 0, last_rise = 0;
  int          starts = 0, stops = 0;
  logic        comp;

  assign comp  = comp_en && slv_on && (dcnt == 2);
  assign scl_i = scl_o & ~st_low;
  assign sda_i = sda_o & (slv_on ? pat_q[8] : 1'b1) & ~comp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    automatic logic lo = 1'b0;
    automatic logic sl, sd;
    if (tok == tok_seen && stretch && slv_on && dcnt == 5 &&
        scl_o && st_cnt < 50) begin
      lo = 1'b1;
      st_cnt <= st_cnt + 1;
    end
    sl = scl_o & ~lo;
    sd = sda_i;
    if (tok != tok_seen) begin
      tok_seen <= tok;
      pat_q    <= pat_init;
      slv_on   <= !sta_cur;
      dcnt     <= 0;
      st_cnt   <= 0;
    end else begin
      if (!scl_p && sl) begin
        cap       <= {cap[8:0], sd};
        per       <= cyc - last_rise;
        last_rise <= cyc;
      end
      if (scl_p && !sl) begin
        if (!slv_on) slv_on <= 1'b1;
        else begin
          pat_q <= {pat_q[7:0], 1'b1};
          dcnt  <= dcnt + 1;
        end
      end
      if (scl_p && sl && sda_p && !sd) starts <= starts + 1;
      if (scl_p && sl && !sda_p && sd) stops <= stops + 1;
    end
    st_low <= lo;
    scl_p  <= sl;
    sda_p  <= sd;
  end

  int errs = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic sta, input logic sto, input logic rd,
                     input logic ack, input logic [7:0] dat,
                     input logic [8:0] pat, output int dur);
    int t0;
    int n;
    @(posedge clk); #1;
    check_eq("ready_before_cmd", cmd_ready, 1'b1);
    cmd_sta = sta; cmd_sto = sto; cmd_rd = rd; cmd_ack = ack;
    cmd_dat = dat; cmd_valid = 1'b1;
    pat_init = pat; sta_cur = sta; tok++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t0 = cyc;
    dur = -1;
    n = 0;
    while (dur < 0 && n < 3000) begin
      @(negedge clk);
      if (done) dur = cyc - t0;
      n++;
    end
  endtask

  int d;
  int ne, nd, nl;

  initial begin
    rstn = 1'b0; cr_en = 1'b1; prescale = 16'd4;
    cmd_valid = 1'b0; cmd_sta = 1'b0; cmd_sto = 1'b0;
    cmd_rd = 1'b0; cmd_ack = 1'b0; cmd_dat = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs",
             {scl_o, sda_o, owned, done, cmd_err, arb_lost, rx_nak, rx_dat},
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    check_eq("reset_ready", cmd_ready, 1'b1);
    @(posedge clk); #1 rstn = 1'b1;

    // Write 0xA4 with START, slave ACKs, end in HOLD
    run(1'b1, 1'b0, 1'b0, 1'b0, 8'hA4, 9'h1FE, d);
    check_eq("t1_dur", d, 200);
    check_eq("t1_nak", rx_nak, 1'b0);
    check_eq("t1_hold_lines", {owned, scl_o, sda_o}, 3'b101);
    #1;
    check_eq("t1_bits", cap[8:0], 9'h148);
    check_eq("t1_period", per, 20);
    check_eq("t1_starts", starts, 1);
    @(negedge clk);
    check_eq("t1_done_pulse", done, 1'b0);

    // Read 0x5C, master NAKs, STOP
    run(1'b0, 1'b1, 1'b1, 1'b1, 8'h00, {8'h5C, 1'b1}, d);
    check_eq("t2_dur", d, 200);
    check_eq("t2_rx", rx_dat, 8'h5C);
    check_eq("t2_nak_kept", rx_nak, 1'b0);
    check_eq("t2_idle", {owned, scl_o, sda_o, cmd_ready}, 4'b0111);
    #1;
    check_eq("t2_bits", cap[9:1], 9'h0B9);
    check_eq("t2_stops", stops, 1);

    // Write 0x96 with stretch of 50 cycles in bit 3
    stretch = 1'b1;
    run(1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 9'h1FE, d);
    stretch = 1'b0;
    check_eq("t3_dur", d, 270);
    check_eq("t3_nak", rx_nak, 1'b0);
    #1;
    check_eq("t3_bits", cap[9:1], 9'h12C);
    check_eq("t3_cond", {starts[7:0], stops[7:0]}, {8'd2, 8'd2});

    // Repeated START from HOLD
    run(1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 9'h1FE, d);
    check_eq("t4a_dur", d, 200);
    run(1'b1, 1'b0, 1'b0, 1'b0, 8'h3B, 9'h1FE, d);
    check_eq("t4_dur", d, 200);
    check_eq("t4_owned", owned, 1'b1);
    #1;
    check_eq("t4_bits", cap[8:0], 9'h076);
    check_eq("t4_cond", {starts[7:0], stops[7:0]}, {8'd4, 8'd2});

    // Disable while holding the bus
    @(posedge clk); #1 cr_en = 1'b0;
    @(negedge clk);
    check_eq("dis_ready", cmd_ready, 1'b0);
    @(negedge clk);
    check_eq("dis_lines", {owned, scl_o, sda_o, done}, 4'b0110);
    @(posedge clk); #1 cr_en = 1'b1;
    @(negedge clk);
    check_eq("dis_ready_back", cmd_ready, 1'b1);

    // Command without START from IDLE is rejected
    @(posedge clk); #1;
    cmd_sta = 1'b0; cmd_sto = 1'b0; cmd_rd = 1'b0; cmd_dat = 8'h55;
    cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    ne = 0; nd = 0; nl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_err) ne++;
      if (done) nd++;
      if (!scl_o || !sda_o) nl++;
    end
    check_eq("t5_err", ne, 1);
    check_eq("t5_nodone", nd, 0);
    check_eq("t5_lines", nl, 0);

    // prescale=0: one-cycle quarters
    prescale = 16'd0;
    run(1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 9'h1FE, d);
    check_eq("p0_dur", d, 44);
    check_eq("p0_nak", rx_nak, 1'b0);
    #1;
    check_eq("p0_bits", cap[9:1], 9'h186);
    prescale = 16'd4;

`ifdef I2C_MST_ARB_EN
    comp_en = 1'b1;
    run(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 9'h1FF, d);
    check_eq("arb_dur", d, 70);
    check_eq("arb_flags", {arb_lost, owned, scl_o, sda_o}, 4'b1011);
    @(negedge clk);
    comp_en = 1'b0;
    check_eq("arb_ready", cmd_ready, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
